// File: rtl/usb4_ser_pkg.sv
// Shared types and constants for the logical-layer serializer scheduler.
package usb4_ser_pkg;

  localparam int SER_DATA_WIDTH = 10;

  typedef enum logic [1:0] {
    DISCONNECTED_S = 2'h0,
    IDLE_S         = 2'h1,
    START          = 2'h2
  } trans_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-port round-robin arbiter. prio_q names the port that wins a tie; it
// starts at port 0 and moves to the other port whenever advance_i accepts a
// grant, so the last-granted port loses the next tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic prio_q, prio_d;

  // Pick a winner: a lone requester always wins, a tie goes to prio_q.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Priority moves away from the port that was just granted.
  always_comb begin
    prio_d = prio_q;
    if (advance_i && (gnt_o != 2'b00)) prio_d = ~gnt_o[1];
  end

  // Priority register, port 0 first out of reset.
  always_ff @(posedge clk) begin
    if (!rst) prio_q <= 1'b0;
    else      prio_q <= prio_d;
  end

endmodule

// File: rtl/serializer_sched.sv
// Sequencing controller and two-port symbol arbiter feeding the 10-bit
// serializer. A mirror phase counter tracks the serializer's symbol boundary;
// the cycle before a boundary is the grant cycle, the boundary is the load.
// Optional feature macro SER_SCHED_IDLE_FILL_EN: keep the link in START and
// send IDLE_SYM when nobody requests at a boundary, instead of dropping to IDLE.
//
// Handshake: a requester raises valid (independent of ready) and holds data
// until it sees ready; the symbol is accepted on the clk edge where
// valid & ready. ready is combinational, high only in a grant cycle, and at
// most one port sees it per cycle.
module serializer_sched
  import usb4_ser_pkg::*;
#(
  parameter int                    DATA_WIDTH = SER_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_SYM   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  link_en,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [1:0]            trans_state,
  output logic [DATA_WIDTH-1:0] parallel_out,
  output logic                  sym_load,
  output logic [15:0]           sym_cnt
);

  localparam int              PH_W    = $clog2(DATA_WIDTH);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DATA_WIDTH - 1);

  trans_state_t          state_q, state_d;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic [DATA_WIDTH-1:0] pout_q, pout_d;
  logic                  load_q, load_d;
  logic [15:0]           cnt_q, cnt_d;

  logic       any_req;
  logic       bnd;
  logic       grant;
  logic       fill;
  logic [1:0] gnt;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({req1_valid, req0_valid}),
    .advance_i (grant),
    .gnt_o     (gnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= DISCONNECTED_S;
    else      state_q <= state_d;
  end

  // Next state: an active symbol always runs to its last phase before the
  // link may leave START, so a falling link_en never truncates a symbol.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISCONNECTED_S: if (link_en) state_d = IDLE_S;
      IDLE_S: begin
        if (!link_en)     state_d = DISCONNECTED_S;
        else if (any_req) state_d = START;
      end
      START: begin
        if (ph_q == PH_LAST) begin
          if (!link_en)     state_d = DISCONNECTED_S;
          else if (any_req) state_d = START;
          else begin
`ifdef SER_SCHED_IDLE_FILL_EN
            state_d = START;
`else
            state_d = IDLE_S;
`endif
          end
        end
      end
      default: state_d = DISCONNECTED_S;
    endcase
  end

  // Outputs: grant/fill decisions and the combinational ready strobes.
  // A disconnect request in the grant cycle suppresses any grant.
  always_comb begin
    any_req = req0_valid | req1_valid;
    bnd     = (state_q == START) && (ph_q == PH_LAST);
    grant   = rst && link_en && any_req && ((state_q == IDLE_S) || bnd);
`ifdef SER_SCHED_IDLE_FILL_EN
    fill    = rst && link_en && !any_req && bnd;
`else
    fill    = 1'b0;
`endif
    req0_ready = grant & gnt[0];
    req1_ready = grant & gnt[1];
  end

  // Datapath next values: phase, symbol register, load strobe, symbol count.
  // The count steps on the edge that enters the load cycle of a real symbol.
  always_comb begin
    ph_d = '0;
    if ((state_q == START) && (state_d == START))
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_W'(1);
    pout_d = pout_q;
    if (grant)     pout_d = gnt[1] ? req1_data : req0_data;
    else if (fill) pout_d = IDLE_SYM;
    load_d = (state_d == START) && (ph_d == '0);
    cnt_d  = grant ? cnt_q + 16'd1 : cnt_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ph_q   <= '0;
      pout_q <= '0;
      load_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ph_q   <= ph_d;
      pout_q <= pout_d;
      load_q <= load_d;
      cnt_q  <= cnt_d;
    end
  end

  assign trans_state  = state_q;
  assign parallel_out = pout_q;
  assign sym_load     = load_q;
  assign sym_cnt      = cnt_q;

endmodule

// File: tb/tb_serializer_sched.sv
// Bench for serializer_sched: directed scenarios followed by random traffic,
// checked against a transaction-level model that reasons in absolute cycle
// numbers (a symbol loaded at cycle L has its grant slot at L+W-1).
module tb_serializer_sched;
  import usb4_ser_pkg::*;

  localparam int         W      = SER_DATA_WIDTH;
  localparam logic [9:0] IDLE_V = 10'h000;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         link_en;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic [1:0]   trans_state;
  logic [W-1:0] parallel_out;
  logic         sym_load;
  logic [15:0]  sym_cnt;

  always #5 clk = ~clk;

  serializer_sched #(.DATA_WIDTH(W), .IDLE_SYM(IDLE_V)) dut (
    .clk          (clk),
    .rst          (rst),
    .link_en      (link_en),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .trans_state  (trans_state),
    .parallel_out (parallel_out),
    .sym_load     (sym_load),
    .sym_cnt      (sym_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  longint       cyc      = 0;
  bit           d_rst    = 1'b0;
  bit           d_link   = 1'b0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] exp_q[$];
  int           m_st     = 0;     // 0 disconnected, 1 idle, 2 active
  longint       m_load_t = 0;     // cycle of the latest load
  bit           m_prio   = 1'b0;  // port that wins a tie
  logic [W-1:0] m_pout   = '0;
  logic [15:0]  m_cnt    = '0;
  logic [W-1:0] last_loaded = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int m_phase();
    return (m_st == 2) ? int'((cyc - m_load_t) % W) : 0;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle();
    bit   v0, v1, any, bnd, slot, win, e_r0, e_r1, e_load;
    logic o_r0, o_r1;
    logic [W-1:0] exp_sym;
    rst        = d_rst;
    link_en    = d_link;
    v0         = q0.size() > 0;
    v1         = q1.size() > 0;
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = v0 ? q0[0] : W'($urandom);
    req1_data  = v1 ? q1[0] : W'($urandom);
    #1;
    any  = v0 | v1;
    bnd  = (m_st == 2) && (m_phase() == W - 1);
    slot = d_rst && d_link && ((m_st == 1) || bnd);
    win  = (v0 && v1) ? m_prio : v1;
    e_r0 = slot && any && !win;
    e_r1 = slot && any && win;
    o_r0 = req0_ready;
    o_r1 = req1_ready;
    check_eq("ready0", {31'd0, o_r0}, {31'd0, e_r0});
    check_eq("ready1", {31'd0, o_r1}, {31'd0, e_r1});
    @(posedge clk);
    #1;
    if (o_r0 && v0) void'(q0.pop_front());
    if (o_r1 && v1) void'(q1.pop_front());
    if (!d_rst) begin
      m_st = 0; m_prio = 1'b0; m_pout = '0; m_cnt = '0;
      exp_q.delete();
    end else if (slot && any) begin
      m_pout   = win ? q1_head_or(v1, req1_data) : q1_head_or(v0, req0_data);
      exp_q.push_back(m_pout);
      m_cnt    = m_cnt + 16'd1;
      m_prio   = ~win;
      m_load_t = cyc + 1;
      m_st     = 2;
    end else begin
      case (m_st)
        0: if (d_link) m_st = 1;
        1: if (!d_link) m_st = 0;
        2: if (bnd) begin
          if (!d_link) m_st = 0;
          else begin
`ifdef SER_SCHED_IDLE_FILL_EN
            m_pout   = IDLE_V;
            exp_q.push_back(IDLE_V);
            m_load_t = cyc + 1;
`else
            m_st = 1;
`endif
          end
        end
        default: m_st = 0;
      endcase
    end
    cyc++;
    e_load = (m_st == 2) && (m_load_t == cyc);
    check_eq("trans_state", {30'd0, trans_state}, m_st);
    check_eq("sym_load", {31'd0, sym_load}, {31'd0, e_load});
    check_eq("sym_cnt", {16'd0, sym_cnt}, {16'd0, m_cnt});
    check_eq("parallel_out", {22'd0, parallel_out}, {22'd0, m_pout});
    if (e_load) begin
      if (exp_q.size() == 0) exp_sym = ~parallel_out;
      else                   exp_sym = exp_q.pop_front();
      check_eq("loaded_sym", {22'd0, parallel_out}, {22'd0, exp_sym});
      last_loaded = parallel_out;
    end
  endtask

  // Data a requester presented this cycle (held stable while valid).
  function automatic logic [W-1:0] q1_head_or(input bit v, input logic [W-1:0] d);
    return v ? d : '0;
  endfunction

  task automatic feed_both(input logic [W-1:0] a, input logic [W-1:0] b);
    if (q0.size() < 2) q0.push_back(a);
    if (q1.size() < 2) q1.push_back(b);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit   found;
    logic [W-1:0] bits_2a5;
    logic [9:0]   exp_bits;
    int           idle_cnt;
    rst = 1'b0; link_en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;

    // Reset with link down, then bring the link up.
    d_rst = 1'b0; d_link = 1'b0;
    repeat (3) cycle();
    d_rst = 1'b1;
    cycle();
    d_link = 1'b1;
    cycle();
    check_eq("link_up_idle", {30'd0, trans_state}, 32'd1);

    // Single symbol 2A5 from port 0, bits LSB first 1,0,1,0,0,1,0,1,0,1.
    q0.push_back(10'h2A5);
    repeat (14) cycle();
    exp_bits = 10'b1010100101;
    bits_2a5 = last_loaded;
    for (int i = 0; i < W; i++)
      check_eq("ser_bit", {31'd0, bits_2a5[i]}, {31'd0, exp_bits[i]});
    check_eq("cnt_after_one", {16'd0, sym_cnt}, 32'd1);

    // Both ports saturated: alternating grants, back-to-back loads.
    repeat (60) begin feed_both(10'h0F0, 10'h30F); cycle(); end

    // Drop link at phase 4 of a symbol; port 1 keeps asking.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      feed_both(10'h0F0, 10'h30F);
      if (m_st == 2 && m_phase() == 4) found = 1'b1;
      else cycle();
    end
    check_eq("reach_ph4", {31'd0, found}, 32'd1);
    d_link = 1'b0;
    q0.delete();
    repeat (15) begin if (q1.size() == 0) q1.push_back(10'h30F); cycle(); end
    check_eq("dis_after_drop", {30'd0, trans_state}, 32'd0);

    // One symbol then silence: fall back to idle or fill.
    q1.delete();
    d_link = 1'b1;
    repeat (2) cycle();
    q0.push_back(10'h155);
    repeat (30) cycle();
`ifdef SER_SCHED_IDLE_FILL_EN
    check_eq("fill_state", {30'd0, trans_state}, 32'd2);
    check_eq("fill_sym", {22'd0, parallel_out}, {22'd0, IDLE_V});
`else
    check_eq("idle_state", {30'd0, trans_state}, 32'd1);
`endif

    // Reset mid-stream at phase 6, then restart.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      feed_both(W'($urandom), W'($urandom));
      if (m_st == 2 && m_phase() == 6) found = 1'b1;
      else cycle();
    end
    check_eq("reach_ph6", {31'd0, found}, 32'd1);
    d_rst = 1'b0;
    cycle();
    check_eq("rst_cnt", {16'd0, sym_cnt}, 32'd0);
    d_rst = 1'b1;
    repeat (30) begin feed_both(W'($urandom), W'($urandom)); cycle(); end

    // Random traffic with occasional link flips and resets.
    idle_cnt = 0;
    repeat (3000) begin
      if ($urandom_range(0, 99) < 30 && q0.size() < 3) q0.push_back(W'($urandom));
      if ($urandom_range(0, 99) < 30 && q1.size() < 3) q1.push_back(W'($urandom));
      if ($urandom_range(0, 99) == 0) d_link = ~d_link;
      if (!d_link && $urandom_range(0, 19) == 0) d_link = 1'b1;
      d_rst = ($urandom_range(0, 299) != 0);
      if (m_st == 1) idle_cnt++;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
